// File: rtl/rm_ihpsg13_1p_march_bist_ctrl.sv
// March C- BIST controller for a single-port bm_bist SRAM macro; checks A_DOUT and reports the first miscompare.
// Optional RM_BIST_CHECKERBOARD_EN adds a second pass with a 0x55/0xAA checkerboard background and fail_pass_o.
module rm_ihpsg13_1p_march_bist_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              A_BIST_CLK,
   input  logic              A_BIST_RST_N,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o,
   output logic [DATA_W-1:0] fail_data_o,
   output logic              A_BIST_EN,
   output logic              A_BIST_MEN,
   output logic              A_BIST_WEN,
   output logic              A_BIST_REN,
   output logic [ADDR_W-1:0] A_BIST_ADDR,
   output logic [DATA_W-1:0] A_BIST_DIN,
   output logic [DATA_W-1:0] A_BIST_BM,
   input  logic [DATA_W-1:0] A_DOUT
`ifdef RM_BIST_CHECKERBOARD_EN
   ,
   output logic              fail_pass_o
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q;
   logic [2:0]        elem_q;
   logic [ADDR_W-1:0] addr_q;
   logic              phase_q;
   logic              last_q;
   logic              cur_pass;
   logic              last_pass;

   logic              men_q, wen_q, ren_q;
   logic [ADDR_W-1:0] port_addr_q;
   logic [DATA_W-1:0] din_q, port_exp_q;
   logic [2:0]        port_elem_q;

   logic              chk_q;
   logic [DATA_W-1:0] chk_exp_q;
   logic [ADDR_W-1:0] chk_addr_q;
   logic [2:0]        chk_elem_q;

   logic              start_acc, down, single, is_read, inv;
   logic              last_in_elem, addr_end, elem_end, final_op;
   logic [DATA_W-1:0] bg, op_data;

`ifdef RM_BIST_CHECKERBOARD_EN
   logic pass_q, port_pass_q, chk_pass_q;
   assign cur_pass  = pass_q;
   assign last_pass = pass_q;
`else
   assign cur_pass  = 1'b0;
   assign last_pass = 1'b1;
`endif

   assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o      = (state_q == S_DONE);
   assign start_acc   = start_i && !busy_o;
   assign A_BIST_EN   = busy_o;
   assign A_BIST_MEN  = men_q;
   assign A_BIST_WEN  = wen_q;
   assign A_BIST_REN  = ren_q;
   assign A_BIST_ADDR = port_addr_q;
   assign A_BIST_DIN  = din_q;
   assign A_BIST_BM   = {DATA_W{busy_o}};

   // Decode the op at the current sequencer position; phase 0 is the read of an r/w pair.
   always_comb begin
      bg = '0;
      if (cur_pass) begin
         for (int i = 0; i < DATA_W; i++) bg[i] = ((i % 2) == 0) ? ~addr_q[0] : addr_q[0];
      end
      inv = 1'b0;
      case (elem_q)
         3'd1, 3'd3: inv = phase_q;
         3'd2, 3'd4: inv = ~phase_q;
         default:    inv = 1'b0;
      endcase
      down         = (elem_q == 3'd3) || (elem_q == 3'd4);
      single       = (elem_q == 3'd0) || (elem_q == 3'd5);
      is_read      = (elem_q != 3'd0) && !phase_q;
      op_data      = inv ? ~bg : bg;
      last_in_elem = single || phase_q;
      addr_end     = down ? (addr_q == '0) : (addr_q == '1);
      elem_end     = last_in_elem && addr_end;
      final_op     = elem_end && (elem_q == 3'd5) && last_pass;
   end

   always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
      if (!A_BIST_RST_N) begin
         state_q     <= S_IDLE;
         elem_q      <= '0;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         last_q      <= 1'b0;
         men_q       <= 1'b0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         port_addr_q <= '0;
         din_q       <= '0;
         port_exp_q  <= '0;
         port_elem_q <= '0;
`ifdef RM_BIST_CHECKERBOARD_EN
         pass_q      <= 1'b0;
         port_pass_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_acc) begin
                  state_q <= S_RUN;
                  elem_q  <= '0;
                  addr_q  <= '0;
                  phase_q <= 1'b0;
                  last_q  <= 1'b0;
`ifdef RM_BIST_CHECKERBOARD_EN
                  pass_q  <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               if (last_q) begin
                  men_q       <= 1'b0;
                  wen_q       <= 1'b0;
                  ren_q       <= 1'b0;
                  port_addr_q <= '0;
                  din_q       <= '0;
                  state_q     <= S_DRAIN;
               end else begin
                  men_q       <= 1'b1;
                  wen_q       <= !is_read;
                  ren_q       <= is_read;
                  port_addr_q <= addr_q;
                  din_q       <= is_read ? '0 : op_data;
                  port_exp_q  <= op_data;
                  port_elem_q <= elem_q;
`ifdef RM_BIST_CHECKERBOARD_EN
                  port_pass_q <= pass_q;
`endif
                  if (final_op) last_q <= 1'b1;
                  // Addresses only wrap when an element ends; down elements start from the top.
                  if (!last_in_elem) begin
                     phase_q <= 1'b1;
                  end else begin
                     phase_q <= 1'b0;
                     if (elem_end) begin
                        elem_q <= (elem_q == 3'd5) ? 3'd0 : elem_q + 3'd1;
                        addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
`ifdef RM_BIST_CHECKERBOARD_EN
                        if (elem_q == 3'd5) pass_q <= 1'b1;
`endif
                     end else begin
                        addr_q <= down ? addr_q - 1'b1 : addr_q + 1'b1;
                     end
                  end
               end
            end
            S_DRAIN: state_q <= S_DONE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Read data returns one cycle after the strobe, so the expectation travels one stage behind it.
   always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
      if (!A_BIST_RST_N) begin
         chk_q       <= 1'b0;
         chk_exp_q   <= '0;
         chk_addr_q  <= '0;
         chk_elem_q  <= '0;
         fail_o      <= 1'b0;
         fail_addr_o <= '0;
         fail_elem_o <= '0;
         fail_data_o <= '0;
`ifdef RM_BIST_CHECKERBOARD_EN
         chk_pass_q  <= 1'b0;
         fail_pass_o <= 1'b0;
`endif
      end else begin
         chk_q      <= ren_q;
         chk_exp_q  <= port_exp_q;
         chk_addr_q <= port_addr_q;
         chk_elem_q <= port_elem_q;
`ifdef RM_BIST_CHECKERBOARD_EN
         chk_pass_q <= port_pass_q;
`endif
         if (start_acc) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_data_o <= '0;
`ifdef RM_BIST_CHECKERBOARD_EN
            fail_pass_o <= 1'b0;
`endif
         end else if (chk_q && !fail_o && (A_DOUT != chk_exp_q)) begin
            fail_o      <= 1'b1;
            fail_addr_o <= chk_addr_q;
            fail_elem_o <= chk_elem_q;
            fail_data_o <= A_DOUT;
`ifdef RM_BIST_CHECKERBOARD_EN
            fail_pass_o <= chk_pass_q;
`endif
         end
      end
   end

endmodule
